// File: rtl/time_counter.sv
// Alarm clock timekeeper: seconds prescaler, BCD HH:MM clock and alarm registers,
// set-mode editing and an edge-triggered alarm ring. All outputs come straight from flops.
module time_counter #(
  parameter int TICKS_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_en,
  input  logic       SW_alarm,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       alarm_on,
  input  logic       stop,
  output logic [3:0] clk_u_min_in,
  output logic [2:0] clk_z_min_in,
  output logic [3:0] clk_u_hour_in,
  output logic [1:0] clk_z_hour_in,
  output logic [3:0] alarm_u_min_in,
  output logic [2:0] alarm_z_min_in,
  output logic [3:0] alarm_u_hour_in,
  output logic [1:0] alarm_z_hour_in,
  output logic       alarm_ring
);

  localparam int SW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [SW-1:0] SEC_MAX = SW'(TICKS_PER_MIN - 1);

  typedef struct packed {
    logic [1:0] zh;
    logic [3:0] uh;
    logic [2:0] zm;
    logic [3:0] um;
  } hhmm_t;

  function automatic hhmm_t adv_hour(input hhmm_t t);
    hhmm_t n;
    n = t;
    if (t.zh == 2'd2 && t.uh >= 4'd3) begin
      n.zh = 2'd0;
      n.uh = 4'd0;
    end else if (t.uh >= 4'd9) begin
      n.uh = 4'd0;
      n.zh = t.zh + 2'd1;
    end else begin
      n.uh = t.uh + 4'd1;
    end
    return n;
  endfunction

  // carry_en=0 is the set-mode edit: minutes wrap 59->00 without touching the hour
  function automatic hhmm_t adv_min(input hhmm_t t, input logic carry_en);
    hhmm_t n;
    n = t;
    if (t.um >= 4'd9) begin
      n.um = 4'd0;
      if (t.zm >= 3'd5) begin
        n.zm = 3'd0;
        if (carry_en) n = adv_hour(n);
      end else begin
        n.zm = t.zm + 3'd1;
      end
    end else begin
      n.um = t.um + 4'd1;
    end
    return n;
  endfunction

  hhmm_t         r_clk, r_alm, w_clk_nxt, w_alm_nxt;
  logic [SW-1:0] r_sec, w_sec_nxt;
  logic          r_match_q, r_ring, w_ring_nxt;
  logic          w_match, w_ring_set, w_ring_clr;

  always_comb begin
    w_clk_nxt = r_clk;
    w_alm_nxt = r_alm;
    w_sec_nxt = r_sec;
    if (set_en) begin
      w_sec_nxt = '0;
      if (SW_alarm) begin
        if (inc_min)  w_alm_nxt = adv_min(w_alm_nxt, 1'b0);
        if (inc_hour) w_alm_nxt = adv_hour(w_alm_nxt);
      end else begin
        if (inc_min)  w_clk_nxt = adv_min(w_clk_nxt, 1'b0);
        if (inc_hour) w_clk_nxt = adv_hour(w_clk_nxt);
      end
    end else if (tick) begin
      if (r_sec == SEC_MAX) begin
        w_sec_nxt = '0;
        w_clk_nxt = adv_min(r_clk, 1'b1);
      end else begin
        w_sec_nxt = r_sec + 1'b1;
      end
    end
  end

  // Ring only on the rising edge of match, so re-arming after stop needs a new minute.
  assign w_match    = (r_clk == r_alm);
  assign w_ring_set = w_match & ~r_match_q & ~set_en & alarm_on;
  assign w_ring_clr = stop | ~alarm_on | set_en | ~w_match;

  always_comb begin
    w_ring_nxt = r_ring;
    if (w_ring_clr)      w_ring_nxt = 1'b0;
    else if (w_ring_set) w_ring_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk     <= '0;
      r_alm     <= '0;
      r_sec     <= '0;
      r_match_q <= 1'b1;
      r_ring    <= 1'b0;
    end else begin
      r_clk     <= w_clk_nxt;
      r_alm     <= w_alm_nxt;
      r_sec     <= w_sec_nxt;
      r_match_q <= w_match;
      r_ring    <= w_ring_nxt;
    end
  end

  assign clk_u_min_in    = r_clk.um;
  assign clk_z_min_in    = r_clk.zm;
  assign clk_u_hour_in   = r_clk.uh;
  assign clk_z_hour_in   = r_clk.zh;
  assign alarm_u_min_in  = r_alm.um;
  assign alarm_z_min_in  = r_alm.zm;
  assign alarm_u_hour_in = r_alm.uh;
  assign alarm_z_hour_in = r_alm.zh;
  assign alarm_ring      = r_ring;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter (TICKS_PER_MIN=4) with an expected-value queue.
module tb_time_counter;

  logic       clk, rst, tick, set_en, SW_alarm, inc_min, inc_hour, alarm_on, stop;
  logic [3:0] clk_u_min_in, clk_u_hour_in, alarm_u_min_in, alarm_u_hour_in;
  logic [2:0] clk_z_min_in, alarm_z_min_in;
  logic [1:0] clk_z_hour_in, alarm_z_hour_in;
  logic       alarm_ring;

  time_counter #(.TICKS_PER_MIN(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_en(set_en), .SW_alarm(SW_alarm),
    .inc_min(inc_min), .inc_hour(inc_hour), .alarm_on(alarm_on), .stop(stop),
    .clk_u_min_in(clk_u_min_in), .clk_z_min_in(clk_z_min_in),
    .clk_u_hour_in(clk_u_hour_in), .clk_z_hour_in(clk_z_hour_in),
    .alarm_u_min_in(alarm_u_min_in), .alarm_z_min_in(alarm_z_min_in),
    .alarm_u_hour_in(alarm_u_hour_in), .alarm_z_hour_in(alarm_z_hour_in),
    .alarm_ring(alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] clk_t, alm_t, ring_t;
  assign clk_t  = {19'd0, clk_z_hour_in, clk_u_hour_in, clk_z_min_in, clk_u_min_in};
  assign alm_t  = {19'd0, alarm_z_hour_in, alarm_u_hour_in, alarm_z_min_in, alarm_u_min_in};
  assign ring_t = {31'd0, alarm_ring};

  function automatic logic [31:0] enc(input int h, input int m);
    return {19'd0, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic pulse(input logic m, input logic h);
    inc_min  = m;
    inc_hour = h;
    step();
    inc_min  = 1'b0;
    inc_hour = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick = 0; set_en = 0; SW_alarm = 0; inc_min = 0; inc_hour = 0;
    alarm_on = 0; stop = 0;
    step(); step();
    push("rst_clk", enc(0, 0));  cmp(clk_t);
    push("rst_alm", enc(0, 0));  cmp(alm_t);
    push("rst_ring", 0);         cmp(ring_t);
    rst = 1'b1;
    step();

    // first minute, then a full day minute by minute
    tick_n(3);
    push("tick3", enc(0, 0));    cmp(clk_t);
    tick_n(1);
    push("tick4", enc(0, 1));    cmp(clk_t);
    for (int k = 2; k <= 1440; k++) begin
      tick_n(4);
      push($sformatf("day_min%0d", k), enc((k % 1440) / 60, k % 60));
      cmp(clk_t);
    end

    // set mode clock edit; tick ignored and sec cleared
    tick_n(2);
    set_en = 1'b1; SW_alarm = 1'b0;
    step();
    tick_n(1);
    push("set_tick_hold", enc(0, 0)); cmp(clk_t);
    repeat (23) pulse(1'b0, 1'b1);
    repeat (59) pulse(1'b1, 1'b0);
    push("edit_clk", enc(23, 59));    cmp(clk_t);
    push("edit_clk_alm", enc(0, 0));  cmp(alm_t);
    set_en = 1'b0;
    pulse(1'b1, 1'b1);
    push("inc_ignored", enc(23, 59)); cmp(clk_t);
    tick_n(3);
    push("sec_cleared", enc(23, 59)); cmp(clk_t);
    tick_n(1);
    push("wrap_day", enc(0, 0));      cmp(clk_t);

    // alarm edit
    set_en = 1'b1; SW_alarm = 1'b1;
    repeat (25) pulse(1'b0, 1'b1);
    push("alm_25h", enc(1, 0));       cmp(alm_t);
    push("alm_25h_clk", enc(0, 0));   cmp(clk_t);
    push("edit_eq_noring", 0);        cmp(ring_t);
    repeat (59) pulse(1'b1, 1'b0);
    push("alm_0159", enc(1, 59));     cmp(alm_t);
    pulse(1'b1, 1'b1);
    push("alm_both", enc(2, 0));      cmp(alm_t);
    repeat (22) pulse(1'b0, 1'b1);
    repeat (2) pulse(1'b1, 1'b0);
    push("alm_0002", enc(0, 2));      cmp(alm_t);

    // ring without stop
    set_en = 1'b0; SW_alarm = 1'b0; alarm_on = 1'b1;
    step();
    tick_n(8);
    push("show_0002", enc(0, 2));     cmp(clk_t);
    push("ring_not_yet", 0);          cmp(ring_t);
    step();
    push("ring_rise", 1);             cmp(ring_t);
    tick_n(3);
    push("ring_hold", 1);             cmp(ring_t);
    tick_n(1);
    push("show_0003", enc(0, 3));     cmp(clk_t);
    push("ring_still", 1);            cmp(ring_t);
    step();
    push("ring_fall", 0);             cmp(ring_t);

    // stop silences for rest of the minute
    set_en = 1'b1; SW_alarm = 1'b1;
    repeat (2) pulse(1'b1, 1'b0);
    set_en = 1'b0; SW_alarm = 1'b0;
    tick_n(4);
    step();
    push("ring2_rise", 1);            cmp(ring_t);
    stop = 1'b1;
    step();
    stop = 1'b0;
    push("stop_clear", 0);            cmp(ring_t);
    for (int i = 0; i < 3; i++) begin
      tick_n(1);
      push($sformatf("stop_quiet%0d", i), 0); cmp(ring_t);
    end
    push("stop_min", enc(0, 4));      cmp(clk_t);
    tick_n(1);
    push("show_0005", enc(0, 5));     cmp(clk_t);

    // alarm_on=0 at match, then re-enable during match via set mode
    alarm_on = 1'b0;
    set_en = 1'b1; SW_alarm = 1'b1;
    repeat (2) pulse(1'b1, 1'b0);
    set_en = 1'b0; SW_alarm = 1'b0;
    tick_n(4);
    step();
    push("off_noring", 0);            cmp(ring_t);
    alarm_on = 1'b1;
    set_en = 1'b1;
    step();
    set_en = 1'b0;
    step(); step();
    push("leave_set_noring", 0);      cmp(ring_t);

    // async reset mid-ring
    set_en = 1'b1; SW_alarm = 1'b1;
    pulse(1'b1, 1'b0);
    set_en = 1'b0; SW_alarm = 1'b0;
    tick_n(4);
    step();
    push("ring3_rise", 1);            cmp(ring_t);
    #1 rst = 1'b0;
    #1;
    push("arst_ring", 0);             cmp(ring_t);
    push("arst_clk", enc(0, 0));      cmp(clk_t);
    push("arst_alm", enc(0, 0));      cmp(alm_t);
    #2 rst = 1'b1;
    step(); step();
    push("post_rst_noring", 0);       cmp(ring_t);
    tick_n(4);
    push("post_rst_min", enc(0, 1));  cmp(clk_t);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter TICKS_PER_MIN, default 60: number of tick pulses per minute; the bench SHALL be able to override it, and legal values are 2..255.
REQ-002 Port clk, input, 1 bit: the single system clock, shared with the display scan logic; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset; rst=0 SHALL force the reset state immediately, independent of clk.
REQ-004 Port tick, input, 1 bit: 1 Hz enable, one clk cycle wide.
REQ-005 Port set_en, input, 1 bit: set mode; 1 freezes timekeeping and enables editing.
REQ-006 Port SW_alarm, input, 1 bit: edit target select; 0 = clock registers, 1 = alarm registers.
REQ-007 Port inc_min, input, 1 bit: increment-minute pulse, one cycle wide, debounced upstream.
REQ-008 Port inc_hour, input, 1 bit: increment-hour pulse, one cycle wide, debounced upstream.
REQ-009 Port alarm_on, input, 1 bit: alarm arm switch.
REQ-010 Port stop, input, 1 bit: silence pulse, one cycle wide.
REQ-011 Ports clk_u_min_in[3:0], clk_z_min_in[2:0], clk_u_hour_in[3:0], clk_z_hour_in[1:0], outputs: BCD clock time digits that feed the display multiplexer.
REQ-012 Ports alarm_u_min_in[3:0], alarm_z_min_in[2:0], alarm_u_hour_in[3:0], alarm_z_hour_in[1:0], outputs: BCD alarm time digits.
REQ-013 Port alarm_ring, output, 1 bit: buzzer drive.

Function
REQ-014 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-015 An internal seconds counter sec SHALL be ceil(log2(TICKS_PER_MIN)) bits wide and count 0..TICKS_PER_MIN-1.
REQ-016 With set_en=0 and tick=1, sec SHALL increment; when sec=TICKS_PER_MIN-1 it SHALL instead wrap to 0 and advance the clock minute in the same edge.
REQ-017 The minute advance SHALL be observable on the outputs one cycle after the tick cycle.
REQ-018 Minute advance SHALL follow the BCD order u_min 9->0 carrying to z_min, and z_min 5->0 carrying into an hour advance.
REQ-019 Hour advance SHALL count u_hour 0..9 while z_hour<2 and 0..3 while z_hour=2, so that 23:59 advances to 00:00.
REQ-020 Every digit SHALL stay within its legal BCD range at all times.
REQ-021 With set_en=1, sec SHALL be held at 0, tick SHALL be ignored, and the clock time SHALL hold except when edited.
REQ-022 With set_en=1, an inc_min pulse SHALL advance the minute of the target selected by SW_alarm, wrapping 59->00 with no carry into the hour.
REQ-023 With set_en=1, an inc_hour pulse SHALL advance the hour of the selected target, wrapping 23->00.
REQ-024 With set_en=1, inc_min and inc_hour asserted in the same cycle SHALL both take effect in that cycle.
REQ-025 With set_en=0, inc_min and inc_hour SHALL be ignored.
REQ-026 Alarm registers SHALL change only through REQ-022 and REQ-023.
REQ-027 match SHALL be defined as all four clock digits equal to the corresponding alarm digits.
REQ-028 match_q SHALL register match every cycle, in both modes.
REQ-029 alarm_ring SHALL set when match=1, match_q=0, set_en=0 and alarm_on=1, i.e. one cycle after the clock first shows the alarm time.
REQ-030 alarm_ring SHALL clear on the next edge after any of: stop=1, alarm_on=0, set_en=1, or match=0 (ring lasts at most one minute).
REQ-031 Clear conditions SHALL take priority over set when both occur in the same cycle.
REQ-032 After a stop, alarm_ring SHALL stay low for the rest of the matching minute, because there is no new match edge.
REQ-033 Leaving set mode while match=1 already holds SHALL NOT ring.
REQ-034 Editing the alarm to equal the current time SHALL NOT ring.

Reset
REQ-035 rst=0 SHALL asynchronously set clock and alarm to 00:00, sec=0, alarm_ring=0 and match_q=1; match_q=1 prevents a ring at 00:00 after reset.
REQ-036 Reset asserted mid-count or while ringing SHALL abort the operation with no residual state.
REQ-037 Reset deassertion SHALL be synchronous to the next clk edge.

Verification
REQ-038 Use TICKS_PER_MIN=4. Apply rst, then 4 ticks -> outputs 00:01 one cycle after the 4th tick; 4*60*24 ticks -> outputs return to 00:00.
REQ-039 Set mode, SW_alarm=0, editing to 23:59, then release and 4 ticks -> 00:00; a tick asserted during set mode -> no change, sec remains 0.
REQ-040 Set mode, SW_alarm=1, 25 inc_hour pulses -> alarm 01:00 with clock unchanged; inc_min and inc_hour in the same cycle from 01:59 -> 02:00.
REQ-041 Alarm 00:02, alarm_on=1, run from 00:00 -> alarm_ring rises exactly one cycle after the outputs show 00:02; with no stop, it falls one cycle after 00:03 appears.
REQ-042 Ringing, pulse stop -> alarm_ring low next cycle and stays low through the remaining ticks of 00:02; alarm_on=0 at the match -> no ring.
REQ-043 Assert rst asynchronously mid-ring (between clk edges) -> alarm_ring and all digits at 0 before the next clk edge.
